// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - ld_state_e : loader FSM states (checksum states are only entered when
//                  IMEM_LOADER_CKSUM_EN is defined)
//   - IMEM_DEPTH / IMEM_AW : default instruction memory geometry
//   - ERR_* : 2-bit error codes reported on ERR_CODE
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 512;
  localparam int unsigned IMEM_AW    = 9;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CKSUM   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StDatLo,
    StDatHi,
    StCkLo,
    StCkHi,
    StError
  } ld_state_e;

  // States in which the loader is consuming bytes from the source.
  function automatic logic is_rx_state(ld_state_e s);
    return (s == StHdrLo) || (s == StHdrHi) || (s == StDatLo) ||
           (s == StDatHi) || (s == StCkLo)  || (s == StCkHi);
  endfunction

endpackage

// File: rtl/ld_watchdog.sv
// Idle-cycle watchdog for the loader.
// Counts cycles while 'enable' is high; 'clear' restarts the count.
// 'expired' is high in the cycle whose increment would bring the count to
// TIMEOUT, so the owner reacts on exactly the TIMEOUT-th idle edge.
// TIMEOUT = 0 disables the watchdog entirely (expired tied low).
// Ports:
//   clk     in  clock, rising edge
//   reset   in  synchronous active-high reset
//   clear   in  restart the idle count
//   enable  in  count this cycle
//   expired out TIMEOUT idle cycles reached on this edge
module ld_watchdog #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count only needs to hold 0 .. TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset || clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = enable && !clear && (cnt_q == LAST);
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader for the 512 x 16-bit instruction memory.
// Frame format on the byte stream: 16-bit word count N (low byte first),
// then N little-endian 16-bit words, then (only with IMEM_LOADER_CKSUM_EN
// defined) a 16-bit little-endian trailer equal to the mod-2^16 sum of the
// words. Words are written to addresses 0 .. N-1 while the CPU is held.
// Build option: IMEM_LOADER_CKSUM_EN enables the checksum trailer.
// Ports:
//   CLK        in  clock, rising edge
//   RESET      in  synchronous active-high reset
//   START      in  begin a load (honoured in IDLE or ERROR only)
//   RX_VALID   in  byte available
//   RX_DATA    in  byte payload
//   RX_READY   out byte accepted this cycle when RX_VALID is high
//   MEM_WE     out registered one-cycle write strobe
//   MEM_WADDR  out write word address
//   MEM_WDATA  out write word data
//   CPU_HOLD   out keep the CPU in reset
//   DONE       out one-cycle pulse on successful completion
//   ERR        out high while in ERROR
//   ERR_CODE   out 0 none, 1 bad length, 2 timeout, 3 checksum
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH   = IMEM_DEPTH,
  parameter int unsigned AW      = IMEM_AW,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          RX_VALID,
  input  logic [7:0]    RX_DATA,
  output logic          RX_READY,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_WADDR,
  output logic [15:0]   MEM_WDATA,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERR,
  output logic [1:0]    ERR_CODE
);

  ld_state_e   state_q;
  logic [7:0]  lo_q;    // low byte of header, data word or trailer
  logic [AW:0] len_q;   // N, 1 .. DEPTH
  logic [AW:0] k_q;     // words written so far
`ifdef IMEM_LOADER_CKSUM_EN
  logic [15:0] cksum_q;
`endif

  logic        accept;
  logic        start_take;
  logic [15:0] word;
  logic        bad_len;
  logic [AW:0] k_next;
  logic        last_word;
  logic        wd_expired;

  always_comb begin
    RX_READY   = is_rx_state(state_q);
    ERR        = (state_q == StError);
    accept     = RX_VALID && RX_READY;
    start_take = START && ((state_q == StIdle) || (state_q == StError));
    word       = {RX_DATA, lo_q};
    bad_len    = (word == 16'd0) || (32'(word) > DEPTH);
    k_next     = k_q + 1'b1;
    last_word  = (k_next == len_q);
  end

  ld_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .reset   (RESET),
    .clear   (accept || start_take),
    .enable  (RX_READY && !accept),
    .expired (wd_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      lo_q      <= '0;
      len_q     <= '0;
      k_q       <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q   <= '0;
`endif
      MEM_WE    <= 1'b0;
      MEM_WADDR <= '0;
      MEM_WDATA <= '0;
      CPU_HOLD  <= 1'b0;
      DONE      <= 1'b0;
      ERR_CODE  <= ERR_NONE;
    end else begin
      MEM_WE <= 1'b0;
      DONE   <= 1'b0;
      if (start_take) begin
        state_q  <= StHdrLo;
        k_q      <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_q  <= '0;
`endif
        ERR_CODE <= ERR_NONE;
        CPU_HOLD <= 1'b1;
      end else if (wd_expired) begin
        // Expiry only happens in receiving states; CPU_HOLD stays high.
        state_q  <= StError;
        ERR_CODE <= ERR_TIMEOUT;
      end else if (accept) begin
        unique case (state_q)
          StHdrLo: begin
            lo_q    <= RX_DATA;
            state_q <= StHdrHi;
          end
          StHdrHi: begin
            if (bad_len) begin
              state_q  <= StError;
              ERR_CODE <= ERR_LEN;
            end else begin
              len_q   <= word[AW:0];
              state_q <= StDatLo;
            end
          end
          StDatLo: begin
            lo_q    <= RX_DATA;
            state_q <= StDatHi;
          end
          StDatHi: begin
            MEM_WE    <= 1'b1;
            MEM_WADDR <= k_q[AW-1:0];
            MEM_WDATA <= word;
            k_q       <= k_next;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q   <= cksum_q + word;
            state_q   <= last_word ? StCkLo : StDatLo;
`else
            if (last_word) begin
              state_q  <= StIdle;
              DONE     <= 1'b1;
              CPU_HOLD <= 1'b0;
            end else begin
              state_q <= StDatLo;
            end
`endif
          end
`ifdef IMEM_LOADER_CKSUM_EN
          StCkLo: begin
            lo_q    <= RX_DATA;
            state_q <= StCkHi;
          end
          StCkHi: begin
            if (word == cksum_q) begin
              state_q  <= StIdle;
              DONE     <= 1'b1;
              CPU_HOLD <= 1'b0;
            end else begin
              state_q  <= StError;
              ERR_CODE <= ERR_CKSUM;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic        RX_READY;
  logic        MEM_WE;
  logic [8:0]  MEM_WADDR;
  logic [15:0] MEM_WDATA;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;
  logic [1:0]  ERR_CODE;

  always #5 CLK = ~CLK;

  imem_loader #(
    .DEPTH   (512),
    .AW      (9),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .RX_VALID  (RX_VALID),
    .RX_DATA   (RX_DATA),
    .RX_READY  (RX_READY),
    .MEM_WE    (MEM_WE),
    .MEM_WADDR (MEM_WADDR),
    .MEM_WDATA (MEM_WDATA),
    .CPU_HOLD  (CPU_HOLD),
    .DONE      (DONE),
    .ERR       (ERR),
    .ERR_CODE  (ERR_CODE)
  );

  // Memory-side observer: records every write and DONE pulse.
  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         obs_q[$];
  int          done_cnt = 0;
  logic [15:0] mem_model [0:511] = '{default: 16'hDEAD};

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      obs_q.push_back('{a: MEM_WADDR, d: MEM_WDATA});
      mem_model[MEM_WADDR] <= MEM_WDATA;
    end
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Frame vectors: pattern 0 random, 1 incrementing, 2 = {1F01,BEEF},
  // 3 = {8000,8001}. ck_xor corrupts the trailer (checksum builds only).
  typedef struct {
    int          n;
    int          pattern;
    int          gapmax;
    logic [15:0] ck_xor;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] fw [0:511];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one byte after 'gap' idle cycles; returns once it is accepted.
  task automatic put(input logic [7:0] b, input int gap);
    bit ok;
    int budget;
    RX_VALID = 1'b0;
    repeat (gap) tick();
    RX_VALID = 1'b1;
    RX_DATA  = b;
    ok       = 1'b0;
    budget   = 0;
    while (!ok && budget < 64) begin
      ok = RX_READY;
      tick();
      budget++;
    end
    RX_VALID = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("hold_after_start", 32'(CPU_HOLD), 32'd1);
    check("ready_after_start", 32'(RX_READY), 32'd1);
    check("errcode_cleared", 32'(ERR_CODE), 32'd0);
  endtask

  function automatic int pick_gap(input int gapmax);
    return (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
  endfunction

  task automatic fill_words(input int n, input int pattern);
    for (int k = 0; k < 512; k++) begin
      case (pattern)
        1:       fw[k] = 16'(k);
        2:       fw[k] = (k == 0) ? 16'h1F01 : 16'hBEEF;
        3:       fw[k] = (k == 0) ? 16'h8000 : 16'h8001;
        default: fw[k] = 16'($urandom);
      endcase
    end
    if (n < 0) fw[0] = 16'h0;
  endtask

  task automatic run_frame(input vec_t v);
    int          base_w;
    int          base_d;
    logic [15:0] sum;
    logic [15:0] hdr;
    bit          good;
    base_w = obs_q.size();
    base_d = done_cnt;
    hdr    = 16'(v.n);
    fill_words(v.n, v.pattern);
    pulse_start();
    put(hdr[7:0], pick_gap(v.gapmax));
    put(hdr[15:8], pick_gap(v.gapmax));
    if (v.exp_code == ERR_LEN) begin
      check("len_err", 32'(ERR), 32'd1);
      check("len_code", 32'(ERR_CODE), 32'(ERR_LEN));
      check("len_hold", 32'(CPU_HOLD), 32'd1);
      repeat (3) tick();
      check("len_persist", 32'(ERR), 32'd1);
      check("len_no_write", 32'(obs_q.size() - base_w), 32'd0);
      check("len_no_done", 32'(done_cnt - base_d), 32'd0);
      return;
    end
    check("hdr_hold", 32'(CPU_HOLD), 32'd1);
    sum = 16'h0;
    for (int k = 0; k < v.n; k++) begin
      put(fw[k][7:0], pick_gap(v.gapmax));
      put(fw[k][15:8], pick_gap(v.gapmax));
      sum = sum + fw[k];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    sum = sum ^ v.ck_xor;
    put(sum[7:0], pick_gap(v.gapmax));
    put(sum[15:8], pick_gap(v.gapmax));
`else
    check("last_we_with_done", 32'(MEM_WE), 32'd1);
`endif
    good = (v.exp_code == ERR_NONE);
    if (good) begin
      check("done_pulse", 32'(DONE), 32'd1);
      check("hold_released", 32'(CPU_HOLD), 32'd0);
      check("no_err", 32'(ERR), 32'd0);
    end else begin
      check("ck_err", 32'(ERR), 32'd1);
      check("ck_code", 32'(ERR_CODE), 32'(v.exp_code));
      check("ck_hold", 32'(CPU_HOLD), 32'd1);
      check("ck_no_done", 32'(DONE), 32'd0);
    end
    repeat (2) tick();
    check("write_count", 32'(obs_q.size() - base_w), 32'(v.n));
    for (int k = 0; k < v.n && base_w + k < obs_q.size(); k++) begin
      check("write_addr", 32'(obs_q[base_w + k].a), 32'(k));
      check("write_data", 32'(obs_q[base_w + k].d), 32'(fw[k]));
    end
    check("done_count", 32'(done_cnt - base_d), good ? 32'd1 : 32'd0);
    check("done_one_cycle", 32'(DONE), 32'd0);
    check("hold_after", 32'(CPU_HOLD), good ? 32'd0 : 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(RX_READY), 32'd0);
    check({tag, "_we"}, 32'(MEM_WE), 32'd0);
    check({tag, "_waddr"}, 32'(MEM_WADDR), 32'd0);
    check({tag, "_wdata"}, 32'(MEM_WDATA), 32'd0);
    check({tag, "_hold"}, 32'(CPU_HOLD), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_code"}, 32'(ERR_CODE), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          base_w;
    logic [15:0] keep2;
    vec_t        rv;

    RESET    = 1'b1;
    START    = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    RESET = 1'b0;
    tick();
    check("idle_ready", 32'(RX_READY), 32'd0);

    vecs.push_back('{n: 2,   pattern: 2, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_NONE});
    vecs.push_back('{n: 0,   pattern: 0, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_LEN});
    vecs.push_back('{n: 3,   pattern: 0, gapmax: 2, ck_xor: 16'h0, exp_code: ERR_NONE});
    vecs.push_back('{n: 513, pattern: 0, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_LEN});
    vecs.push_back('{n: 1,   pattern: 0, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_NONE});
    vecs.push_back('{n: 512, pattern: 1, gapmax: 3, ck_xor: 16'h0, exp_code: ERR_NONE});
    vecs.push_back('{n: 7,   pattern: 0, gapmax: 5, ck_xor: 16'h0, exp_code: ERR_NONE});
`ifdef IMEM_LOADER_CKSUM_EN
    vecs.push_back('{n: 2,   pattern: 3, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_NONE});
    vecs.push_back('{n: 2,   pattern: 3, gapmax: 1, ck_xor: 16'h3, exp_code: ERR_CKSUM});
    vecs.push_back('{n: 4,   pattern: 0, gapmax: 1, ck_xor: 16'h0, exp_code: ERR_NONE});
`endif
    foreach (vecs[i]) run_frame(vecs[i]);

    // Full-depth image ends at 511 with data 0x01FF.
    check("full_last_addr", 32'(mem_model[511]), 32'h01FF);

    // Stall after the first data byte: timeout exactly TO cycles later.
    base_w = obs_q.size();
    pulse_start();
    put(8'd2, 0);
    put(8'd0, 0);
    put(8'h11, 0);
    repeat (TO - 1) tick();
    check("to_not_early", 32'(ERR), 32'd0);
    tick();
    check("to_err", 32'(ERR), 32'd1);
    check("to_code", 32'(ERR_CODE), 32'(ERR_TIMEOUT));
    check("to_hold", 32'(CPU_HOLD), 32'd1);
    check("to_ready", 32'(RX_READY), 32'd0);
    repeat (2) tick();
    check("to_no_write", 32'(obs_q.size() - base_w), 32'd0);

    rv = '{n: 4, pattern: 0, gapmax: 2, ck_xor: 16'h0, exp_code: ERR_NONE};
    run_frame(rv);

    // RESET while in DAT_HI with the high byte on offer.
    keep2  = mem_model[2];
    base_w = obs_q.size();
    fill_words(4, 0);
    pulse_start();
    put(8'd4, 0);
    put(8'd0, 0);
    for (int k = 0; k < 2; k++) begin
      put(fw[k][7:0], 0);
      put(fw[k][15:8], 0);
    end
    put(fw[2][7:0], 0);
    RESET    = 1'b1;
    RX_VALID = 1'b1;
    RX_DATA  = fw[2][15:8];
    tick();
    RESET    = 1'b0;
    RX_VALID = 1'b0;
    check_reset_outputs("midreset");
    repeat (4) tick();
    check("midreset_writes", 32'(obs_q.size() - base_w), 32'd2);
    check("midreset_w0", 32'(mem_model[0]), 32'(fw[0]));
    check("midreset_w1", 32'(mem_model[1]), 32'(fw[1]));
    check("midreset_w2_kept", 32'(mem_model[2]), 32'(keep2));
    check("midreset_idle", 32'(CPU_HOLD), 32'd0);

    rv = '{n: 5, pattern: 0, gapmax: 0, ck_xor: 16'h0, exp_code: ERR_NONE};
    run_frame(rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and write-port controller for the 512 × 16-bit instruction memory. Accepts a framed byte stream (length header, little-endian words), sequences word writes into the instruction memory and holds the CPU out of execution while the image is in flight. Sits between the board-level byte source and the instruction memory's write port; the CPU fetch path is untouched apart from `CPU_HOLD`.

## Interface
- `DEPTH`, 512: instruction memory words; must be a power of two.
- `AW`, 9: word-address width, equal to log2(`DEPTH`).
- `TIMEOUT`, 1000000: maximum idle cycles between accepted bytes mid-frame; 0 disables the timeout.

- `CLK`  in  1: single clock. All logic is on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `START`  in  1: level sampled each cycle; begins a load when in IDLE or ERROR.
- `RX_VALID`  in  1: byte source has a byte.
- `RX_DATA`  in  8: byte payload.
- `RX_READY`  out  1: loader accepts a byte this cycle.
- `MEM_WE`  out  1: write strobe to the instruction memory.
- `MEM_WADDR`  out  `AW`: word address.
- `MEM_WDATA`  out  16: word data.
- `CPU_HOLD`  out  1: keeps the CPU in reset while high.
- `DONE`  out  1: one-cycle pulse when a load completes successfully.
- `ERR`  out  1: high while in ERROR.
- `ERR_CODE`  out  2: 0 = none, 1 = bad length, 2 = timeout, 3 = checksum.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, CK_LO, CK_HI, ERROR. CK_LO and CK_HI exist only when the checksum feature is compiled in.
- A byte is accepted on a rising edge where `RX_VALID && RX_READY`.
- `RX_READY` is 1 in HDR_*, DAT_* and CK_* states and 0 in IDLE and ERROR. It is decoded from state.
- Transitions:
  - IDLE or ERROR with `START` → HDR_LO. This clears the word counter, the checksum and `ERR_CODE`.
  - HDR_LO → HDR_HI → length N (16-bit, low byte first).
  - If N == 0 or N > `DEPTH` → ERROR, code 1. Otherwise → DAT_LO.
  - DAT_LO holds the low byte. DAT_HI on accept registers the write (`{hi, lo}` at address k) and increments k.
  - When k reaches N → CK_LO if checksum is enabled, else completion.
  - Otherwise DAT_HI → DAT_LO.
- Completion: → IDLE, with `DONE` pulsed for one cycle and `CPU_HOLD` released in the same cycle.
- `START` is ignored outside IDLE and ERROR.
- Word address `MEM_WADDR` = k[`AW`-1:0]. No wrap can occur because N ≤ `DEPTH`.
- Words at addresses ≥ N are not written and retain their prior contents.
- Timeout: a counter clears on each accepted byte and on entry to HDR_LO.
  - It increments every cycle in a receiving state without an accept.
  - On reaching `TIMEOUT` → ERROR, code 2.
- ERROR: `CPU_HOLD` stays 1. The state persists until `START` or `RESET`.
- Reset values: state IDLE, `RX_READY` 0, `MEM_WE` 0, `MEM_WADDR` 0, `MEM_WDATA` 0, `CPU_HOLD` 0, `DONE` 0, `ERR` 0, `ERR_CODE` 0.
- `RESET` mid-frame aborts the frame immediately. Partially written words remain as written; `RESET` does not clean them up.

## Timing
- `CPU_HOLD` rises in the cycle after `START` is sampled.
- `MEM_WE` is registered. It is high for exactly one cycle, the cycle after the DAT_HI accept, with `MEM_WADDR` and `MEM_WDATA` valid in that same cycle.
- Back-to-back bytes are sustainable at one byte per cycle, which gives a minimum of 2 cycles per word.
- `DONE` is asserted in the cycle after the final accepted byte. With checksum disabled, the final `MEM_WE` and `DONE` coincide.
- `START` sampled in the same cycle as a timeout expiry in ERROR: `START` wins from the next cycle.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - A 16-bit trailer follows the data, low byte first.
  - The trailer is compared against the mod-2^16 sum of all N words.
  - Match → completion. Mismatch → ERROR, code 3, with `CPU_HOLD` held.
- Undefined:
  - No trailer and no checksum logic.
  - Code 3 is never produced.
  - Completion occurs after the last DAT_HI accept.

## Structure
- Shared package `imem_pkg` holds:
  - State enum.
  - `IMEM_DEPTH` (512) and `IMEM_AW` (9).
  - `ERR_*` codes (2-bit).
- Sub-module `ld_watchdog`: a parameterised idle counter with clear, enable and expired outputs. `TIMEOUT` = 0 ties expired low.
- Remaining logic (FSM, byte assembly, counter, checksum) stays in `imem_loader`.

## Test plan
- Reset, then frame N=2, words 0x1F01, 0xBEEF, byte per cycle:
  - `MEM_WE` pulses at address 0 (0x1F01) and address 1 (0xBEEF).
  - `DONE` pulses once.
  - `CPU_HOLD` 1 from the cycle after `START` until `DONE`.
- Header N=0, and separately N=513:
  - ERROR, `ERR_CODE`=1, no `MEM_WE`, `CPU_HOLD`=1.
  - A fresh `START` with a valid frame recovers.
- `TIMEOUT`=16, stall `RX_VALID` after the first data byte:
  - ERROR with code 2 exactly 16 cycles after the last accept.
  - No write for the partial word.
- N=512 of incrementing words with random `RX_VALID` gaps:
  - Final write at address 511 with data 0x01FF.
  - No write at address 0 after address 511.
- With `IMEM_LOADER_CKSUM_EN`:
  - Words 0x8000, 0x8001 with trailer 0x0001 → `DONE`.
  - Trailer 0x0002 → `ERR_CODE`=3, `CPU_HOLD` stays 1.
- `RESET` asserted mid-DAT_HI:
  - The next cycle shows all outputs at reset values.
  - Earlier words are unchanged and no further `MEM_WE` occurs.
